// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store word bridge.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. Optional macro LSU_MISALIGN_TRAP_EN selects trap-vs-align behaviour in the top.
package lsu_pkg;

  // funct3 memory access codes
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  // Access sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_RMW_RD,
    S_MERGE,
    S_WRITE,
    S_RESP
  } state_e;

  // Every memory access is a full word
  localparam logic [2:0] MEM_TYPE_WORD = 3'b010;

  // Codes with no defined access, plus unsigned variants used as stores
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  // Halfword on an odd byte, or word not on a word boundary
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
  endfunction

  // Force the lane onto the natural boundary of the access size
  function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] lane);
    logic [1:0] r;
    case (f3[1:0])
      2'b01:   r = {lane[1], 1'b0};
      2'b10:   r = 2'b00;
      default: r = lane;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_word_bridge_lane_mux.sv
// Lane extract/extend for loads and byte/halfword merge for stores.
// Latency: purely combinational.
// Backpressure: none; caller supplies an already-aligned lane.
import lsu_pkg::*;

module lsu_lane_mux (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  shamt;
  logic [31:0] lane_shift;
  logic [31:0] mask;

  assign shamt      = {lane, 3'b000};
  assign lane_shift = word >> shamt;

  // Pick the addressed byte/halfword and extend it per funct3
  always_comb begin
    load_data = lane_shift;
    case (funct3)
      3'b000:  load_data = {{24{lane_shift[7]}}, lane_shift[7:0]};
      3'b001:  load_data = {{16{lane_shift[15]}}, lane_shift[15:0]};
      3'b100:  load_data = {24'h0, lane_shift[7:0]};
      3'b101:  load_data = {16'h0, lane_shift[15:0]};
      default: load_data = lane_shift;
    endcase
  end

  // Replace the addressed byte/halfword of the old word with the low store bits
  always_comb begin
    mask = 32'hFFFF_FFFF;
    case (funct3[1:0])
      2'b00:   mask = 32'h0000_00FF << shamt;
      2'b01:   mask = 32'h0000_FFFF << shamt;
      default: mask = 32'hFFFF_FFFF;
    endcase
    store_word = (word & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/lsu_word_bridge.sv
// Load/store bridge: base+offset to word index, full-word accesses, sub-word via lane mux / RMW.
// Latency: loads and sw 3 cycles accept->resp_valid, sb/sh 4, faults 2.
// Backpressure: req_ready only in IDLE, one request in flight. Macro LSU_MISALIGN_TRAP_EN traps misalignment.
import lsu_pkg::*;

module lsu_word_bridge #(
  parameter int ADDR_W = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [2:0]  mem_type,
  input  logic [31:0] mem_rdata
);

  state_e state, state_n;

  logic [31:0]       ea;
  logic [ADDR_W-1:0] ea_idx;
  logic              unused_ea_hi;
  logic              accept;
  logic              in_fault;
  logic              sub_store;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        lane_q;
  logic              fault_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       merge_q;

  logic [1:0]        lane_eff;
  logic [31:0]       mux_word;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  assign ea           = req_base + req_offset;
  assign ea_idx       = ea[ADDR_W+1:2];
  // Address bits above the memory depth wrap and are deliberately dropped
  assign unused_ea_hi = ^ea[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign in_fault = f3_illegal(req_we, req_funct3) || misaligned(req_funct3, ea[1:0]);
`else
  assign in_fault = f3_illegal(req_we, req_funct3);
`endif

  // sb/sh go straight to the read half of RMW so they finish in 4 cycles
  assign sub_store = req_we && (req_funct3[2:1] == 2'b00);
  assign accept    = req_valid && req_ready;

  assign lane_eff   = align_lane(f3_q, lane_q);
  assign mux_word   = (state == S_LOAD) ? mem_rdata : merge_q;
  assign mem_type   = MEM_TYPE_WORD;
  assign mem_addr   = {{(32-ADDR_W){1'b0}}, addr_q};
  assign resp_fault = (state == S_RESP) && fault_q;

  lsu_lane_mux u_lane_mux (
    .word       (mux_word),
    .lane       (lane_eff),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and strobe decode
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = (sub_store && !in_fault) ? S_RMW_RD : S_CHECK;
      end
      S_CHECK: begin
        if (fault_q)              state_n = S_RESP;
        else if (!we_q)           state_n = S_LOAD;
        else if (f3_q[1:0] == 2'b10) state_n = S_WRITE;
        else                      state_n = S_RMW_RD;
      end
      S_LOAD: begin
        mem_re  = 1'b1;
        state_n = S_RESP;
      end
      S_RMW_RD: begin
        mem_re  = 1'b1;
        state_n = S_MERGE;
      end
      S_MERGE: state_n = S_WRITE;
      S_WRITE: begin
        mem_we  = 1'b1;
        state_n = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request capture; the fault verdict is taken once, from the live request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      wdata_q <= 32'h0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      fault_q <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
      idx_q   <= ea_idx;
      lane_q  <= ea[1:0];
      fault_q <= in_fault;
    end
  end

  // Memory-side datapath: address only moves when entering an access state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      mem_wdata  <= 32'h0;
      merge_q    <= 32'h0;
      resp_rdata <= 32'h0;
    end else begin
      if (accept && (state_n == S_RMW_RD)) addr_q <= ea_idx;
      if ((state == S_CHECK) && (state_n != S_RESP)) addr_q <= idx_q;
      if ((state == S_CHECK) && (state_n == S_WRITE)) mem_wdata <= wdata_q;
      if (state == S_RMW_RD) merge_q <= mem_rdata;
      if (state == S_MERGE) mem_wdata <= store_word;
      if (state == S_LOAD) resp_rdata <= load_data;
    end
  end

endmodule

// File: tb/tb_lsu_word_bridge.sv
// Scoreboard bench for lsu_word_bridge: random and directed requests against a byte-level model.
// Latency: expectations carry the accept cycle so response latency is checked.
// Backpressure: driver waits on req_ready; a monitor pops expectations on resp_valid.
module tb_lsu_word_bridge;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [2:0]  mem_type;
  logic [31:0] mem_rdata;

  lsu_word_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_type   (mem_type),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory with combinational read
  logic [31:0] mem [DEPTH];
  bit          mem_init_done = 1'b0;

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'h8081_F2A3;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[ADDR_W-1:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[ADDR_W-1:0]];

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rdata;

  typedef struct {
    int          acc;
    int          lat;
    logic        fault;
    logic [31:0] rdata;
    int          n_re;
    int          n_we;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;
  int n_re_seen = 0;
  int n_we_seen = 0;
  int we_total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte-addressed view of the access: size, natural alignment, extension
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd, input int acc,
                       output exp_t e);
    logic [31:0] ea, val, mask;
    int idx, lane, nb;
    logic illegal;
    ea   = base + off;
    idx  = int'((ea >> 2) % DEPTH);
    lane = int'(ea % 4);
    nb   = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3 >= 3'b100);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((lane % nb) != 0) illegal = 1'b1;
`endif
    lane    = lane - (lane % nb);
    e.acc   = acc;
    e.waddr = 32'(idx);
    e.wdata = 32'h0;
    e.n_re  = 0;
    e.n_we  = 0;
    e.fault = 1'b0;
    if (illegal) begin
      e.fault = 1'b1;
      e.lat   = 2;
      e.rdata = ref_rdata;
    end else if (!we) begin
      val = ref_mem[idx] >> (8 * lane);
      if (nb == 1) begin
        val = val & 32'hFF;
        if (!f3[2] && val[7]) val = val | 32'hFFFF_FF00;
      end else if (nb == 2) begin
        val = val & 32'hFFFF;
        if (!f3[2] && val[15]) val = val | 32'hFFFF_0000;
      end
      ref_rdata = val;
      e.rdata   = val;
      e.lat     = 3;
      e.n_re    = 1;
    end else begin
      e.n_we  = 1;
      e.rdata = ref_rdata;
      if (nb == 4) begin
        e.lat   = 3;
        e.wdata = wd;
      end else begin
        e.lat   = 4;
        e.n_re  = 1;
        mask    = ((nb == 1) ? 32'hFF : 32'hFFFF) << (8 * lane);
        e.wdata = (ref_mem[idx] & ~mask) | ((wd << (8 * lane)) & mask);
      end
      ref_mem[idx] = e.wdata;
    end
  endtask

  task automatic randomize_inputs();
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_base   = $urandom;
    req_offset = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: req_ready got 0 expected 1 within 100 cycles");
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd);
    exp_t e;
    wait_ready();
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
    model(we, f3, base, off, wd, cyc, e);
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    randomize_inputs();
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending got %0d expected 0", sbq.size());
    end
  endtask

  // Monitor: memory strobes and responses checked against queued expectations
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      n_re_seen = 0;
      n_we_seen = 0;
    end else begin
      if (mem_re || mem_we) check("re_we_exclusive", 32'(mem_re & mem_we), 32'h0);
      if (mem_re) n_re_seen++;
      if (mem_we) begin
        n_we_seen++;
        we_total++;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: mem_we got 1 expected 0 at addr %h", mem_addr);
        end else begin
          check("wr_addr", mem_addr, sbq[0].waddr);
          check("wr_data", mem_wdata, sbq[0].wdata);
        end
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: resp_valid got 1 expected 0");
        end else begin
          e = sbq.pop_front();
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
          check("resp_fault", 32'(resp_fault), 32'(e.fault));
          check("resp_rdata", resp_rdata, e.rdata);
          check("read_count", 32'(n_re_seen), 32'(e.n_re));
          check("write_count", 32'(n_we_seen), 32'(e.n_we));
        end
        n_re_seen = 0;
        n_we_seen = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    check({tag, "_resp_fault"}, 32'(resp_fault), 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check({tag, "_mem_re"}, 32'(mem_re), 32'h0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_base   = 32'h0;
    req_offset = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    ref_rdata = 32'h0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check("mem_type", 32'(mem_type), 32'h2);
    rst_n = 1'b1;

    // Directed cases around word 5 = 8081_F2A3
    issue(1'b0, 3'b000, 32'd20, 32'd1, 32'h0);              // lb
    issue(1'b0, 3'b100, 32'd20, 32'd1, 32'h0);              // lbu
    issue(1'b0, 3'b001, 32'd22, 32'd0, 32'h0);              // lh
    issue(1'b0, 3'b101, 32'd22, 32'd0, 32'h0);              // lhu
    issue(1'b1, 3'b000, 32'd20, 32'd1, 32'h1234_5677);      // sb
    issue(1'b0, 3'b010, 32'd20, 32'd0, 32'h0);              // lw merged word
    issue(1'b1, 3'b010, 32'd8, 32'hFFFF_FFFC, 32'hDEAD_BEEF); // sw
    issue(1'b0, 3'b010, 32'd6, 32'd0, 32'h0);               // lw at byte 6
    issue(1'b0, 3'b111, 32'd20, 32'd0, 32'h0);              // illegal
    issue(1'b1, 3'b100, 32'd20, 32'd0, 32'h0);              // illegal store
    issue(1'b0, 3'b011, 32'd20, 32'd0, 32'h0);              // illegal
    issue(1'b1, 3'b001, 32'd40, 32'd2, 32'hCAFE_55AA);      // sh
    issue(1'b0, 3'b010, 32'd40, 32'd0, 32'h0);              // lw sees sh
    drain();

    // Reset in the MERGE cycle of an sh: the write must never happen
    wait_ready();
    wt0        = we_total;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_base   = 32'd20;
    req_offset = 32'd2;
    req_wdata  = 32'h0000_AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrmw");
    ref_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_hold_mem_we", 32'(mem_we), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'h1);
    check("no_write_after_rst", 32'(we_total), 32'(wt0));
    issue(1'b0, 3'b001, 32'd22, 32'd0, 32'h0);              // word 5 upper half untouched
    drain();

    // Random traffic, addresses wrap through the full 32-bit space
    for (int n = 0; n < 300; n++) begin
      logic [31:0] b, o;
      b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 2047));
      o = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), b, o, $urandom);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
